// File: rtl/reduce_pkg.sv
// Shared types and identity values for the multi-lane reduction ALU.
package reduce_pkg;

  typedef enum logic [2:0] {
    OP_SUM    = 3'd0,
    OP_OR     = 3'd1,
    OP_AND    = 3'd2,
    OP_XOR    = 3'd3,
    OP_MIN    = 3'd4,
    OP_MAX    = 3'd5,
    OP_ARGMIN = 3'd6,
    OP_ARGMAX = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [63:0] signed_max(int bits);
    return (64'd1 << (bits - 1)) - 64'd1;
  endfunction

  // Seed value for the running accumulator, sign-extended into 64 bits so
  // callers can truncate to any accumulator width. ARG ops seed the compare
  // value; their index seed is always 0.
  function automatic logic [63:0] op_identity(op_t op, int bits);
    case (op)
      OP_AND:               return (64'd1 << bits) - 64'd1;
      OP_MIN, OP_ARGMIN:    return signed_max(bits);
      OP_MAX, OP_ARGMAX:    return ~signed_max(bits);
      default:              return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/lane_reduce_tree.sv
// Combinational masked combine of one LANES-wide slice, yielding a partial
// value and the index of the winning element for compare-type ops.
module lane_reduce_tree
  import reduce_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int LANES    = 4,
  parameter int ACC_BITS = 14,
  parameter int IW       = 6
) (
  input  logic [2:0]                 op,
  input  logic signed [BITS-1:0]     elem [LANES],
  input  logic [LANES-1:0]           mask,
  input  logic [IW-1:0]              base_idx,
  output logic signed [ACC_BITS-1:0] val,
  output logic [IW-1:0]              idx
);

  always_comb begin
    val = ACC_BITS'(op_identity(op_t'(op), BITS));
    idx = base_idx;
    // Strict compares keep the lowest lane on ties.
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) begin
        case (op_t'(op))
          OP_SUM: val = val + $signed(ACC_BITS'(elem[l]));
          OP_OR:  val = val | ACC_BITS'($unsigned(elem[l]));
          OP_AND: val = val & ACC_BITS'($unsigned(elem[l]));
          OP_XOR: val = val ^ ACC_BITS'($unsigned(elem[l]));
          OP_MIN, OP_ARGMIN: begin
            if ($signed(ACC_BITS'(elem[l])) < val) begin
              val = $signed(ACC_BITS'(elem[l]));
              idx = base_idx + IW'(l);
            end
          end
          OP_MAX, OP_ARGMAX: begin
            if ($signed(ACC_BITS'(elem[l])) > val) begin
              val = $signed(ACC_BITS'(elem[l]));
              idx = base_idx + IW'(l);
            end
          end
          default: val = val;
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_lane_reduce_alu.sv
// Vector reduction ALU: captures an N-element operand vector on start and
// folds LANES elements per cycle into a single registered result.
module multi_lane_reduce_alu
  import reduce_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int N        = 64,
  parameter int LANES    = 4,
  parameter int ACC_BITS = BITS + $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [BITS-1:0]     in [N],
  input  logic [$clog2(N):0]         in_len,
  input  logic [2:0]                 op,
  input  logic                       start,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_BITS-1:0] result
);

  localparam int IW = $clog2(N);
  localparam int LW = IW + 1;

  state_t                     state;
  op_t                        op_q;
  logic [LW-1:0]              len_q;
  logic [LW-1:0]              base;
  logic signed [BITS-1:0]     in_q [N];
  logic signed [ACC_BITS-1:0] acc, acc_nxt, tree_val, seed;
  logic [IW-1:0]              acc_idx, idx_nxt, tree_idx;
  logic signed [BITS-1:0]     lane_elem [LANES];
  logic [LANES-1:0]           lane_mask;
  logic [LW-1:0]              len_clamped;

  function automatic logic signed [ACC_BITS-1:0] finalize(op_t o,
                                                          logic signed [ACC_BITS-1:0] a,
                                                          logic [IW-1:0] ix);
    if (o == OP_ARGMIN || o == OP_ARGMAX) return ACC_BITS'(ix);
    return a;
  endfunction

  always_comb begin
    len_clamped = (in_len > LW'(N)) ? LW'(N) : in_len;
    seed        = ACC_BITS'(op_identity(op_t'(op), BITS));
  end

  // Lane slice selection from the captured vector
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_elem[l] = in_q[IW'(base + LW'(l))];
      lane_mask[l] = (base + LW'(l)) < len_q;
    end
  end

  lane_reduce_tree #(
    .BITS    (BITS),
    .LANES   (LANES),
    .ACC_BITS(ACC_BITS),
    .IW      (IW)
  ) u_tree (
    .op      (op_q),
    .elem    (lane_elem),
    .mask    (lane_mask),
    .base_idx(IW'(base)),
    .val     (tree_val),
    .idx     (tree_idx)
  );

  // Fold the slice into the accumulator
  always_comb begin
    acc_nxt = acc;
    idx_nxt = acc_idx;
    case (op_q)
      OP_SUM: acc_nxt = acc + tree_val;
      OP_OR:  acc_nxt = acc | tree_val;
      OP_AND: acc_nxt = acc & tree_val;
      OP_XOR: acc_nxt = acc ^ tree_val;
      OP_MIN, OP_ARGMIN: begin
        if (tree_val < acc) begin
          acc_nxt = tree_val;
          idx_nxt = tree_idx;
        end
      end
      OP_MAX, OP_ARGMAX: begin
        if (tree_val > acc) begin
          acc_nxt = tree_val;
          idx_nxt = tree_idx;
        end
      end
      default: acc_nxt = acc;
    endcase
  end

  // Operand capture, only on an accepted start
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      in_q  <= in;
      op_q  <= op_t'(op);
      len_q <= len_clamped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      base      <= '0;
      acc       <= '0;
      acc_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= seed;
            acc_idx <= '0;
            base    <= '0;
            busy    <= 1'b1;
            if (len_clamped == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= finalize(op_t'(op), seed, '0);
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc     <= acc_nxt;
          acc_idx <= idx_nxt;
          if (base + LW'(LANES) >= len_q) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= finalize(op_q, acc_nxt, idx_nxt);
            base      <= '0;
          end else begin
            base <= base + LW'(LANES);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_lane_reduce_alu.sv
// Scoreboard bench for multi_lane_reduce_alu: randomized reductions checked
// against a plain-arithmetic reference model.
module tb_multi_lane_reduce_alu;

  localparam int BITS     = 8;
  localparam int N        = 64;
  localparam int LANES    = 4;
  localparam int ACC_BITS = BITS + $clog2(N);

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic signed [BITS-1:0]     din [N];
  logic [$clog2(N):0]         in_len;
  logic [2:0]                 op;
  logic                       start;
  logic                       busy;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [ACC_BITS-1:0] result;

  typedef struct {
    logic signed [ACC_BITS-1:0] res;
    int                         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   seen   = 1'b0;
  int   vals [N];

  multi_lane_reduce_alu #(
    .BITS    (BITS),
    .N       (N),
    .LANES   (LANES),
    .ACC_BITS(ACC_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (din),
    .in_len   (in_len),
    .op       (op),
    .start    (start),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: reduce the first min(len,N) elements of vals directly.
  function automatic longint model(int o, int len);
    int     l;
    longint r;
    int     bi;
    l = (len > N) ? N : len;
    case (o)
      0: begin r = 0;   for (int i = 0; i < l; i++) r += vals[i]; end
      1: begin r = 0;   for (int i = 0; i < l; i++) r = r | (vals[i] & 255); end
      2: begin r = 255; for (int i = 0; i < l; i++) r = r & (vals[i] & 255); end
      3: begin r = 0;   for (int i = 0; i < l; i++) r = r ^ (vals[i] & 255); end
      4: begin r = 127;  for (int i = 0; i < l; i++) if (vals[i] < r) r = vals[i]; end
      5: begin r = -128; for (int i = 0; i < l; i++) if (vals[i] > r) r = vals[i]; end
      6: begin bi = 0; for (int i = 1; i < l; i++) if (vals[i] < vals[bi]) bi = i; r = bi; end
      default: begin bi = 0; for (int i = 1; i < l; i++) if (vals[i] > vals[bi]) bi = i; r = bi; end
    endcase
    return r;
  endfunction

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fill_random();
    logic [7:0] b;
    for (int i = 0; i < N; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 1) ? 8'h7f : 8'h80;
      vals[i] = int'($signed(b));
    end
  endtask

  // Drive a request, push its expectation, then scramble the inputs so any
  // dependence on uncaptured operands shows up as a mismatch.
  task automatic issue(int o, int len, bit hold);
    int   l;
    exp_t e;
    for (int i = 0; i < N; i++) din[i] = BITS'(vals[i]);
    in_len = 7'(len);
    op     = 3'(o);
    start  = 1'b1;
    @(posedge clk);
    #1;
    l     = (len > N) ? N : len;
    e.res = ACC_BITS'(model(o, len));
    e.cyc = cyc + (l + LANES - 1) / LANES;
    sb.push_back(e);
    if (!hold) start = 1'b0;
    for (int i = 0; i < N; i++) din[i] = BITS'($urandom);
    in_len = 7'($urandom);
    op     = 3'($urandom);
  endtask

  task automatic complete(int delay);
    int k;
    if (delay == 0) out_ready = 1'b1;
    @(negedge clk);
    k = 0;
    while (!out_valid && k < 40) begin
      chk("busy_run", busy, 1);
      @(negedge clk);
      k++;
    end
    if (!out_valid) begin
      chk("valid_timeout", out_valid, 1);
      sb.delete();
      out_ready = 1'b0;
      start     = 1'b0;
      return;
    end
    chk("busy_done", busy, 1);
    if (delay > 0) begin
      repeat (delay) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    start     = 1'b0;
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  // Monitor: every cycle a result is offered it must equal the head entry.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: result %0d with empty scoreboard", result);
      end else begin
        checks++;
        if (result !== sb[0].res) begin
          errors++;
          $display("FAIL result: got %0d, expected %0d", result, sb[0].res);
        end
        if (!seen) begin
          seen = 1'b1;
          checks++;
          if (cyc != sb[0].cyc) begin
            errors++;
            $display("FAIL latency: valid at edge %0d, expected edge %0d", cyc, sb[0].cyc);
          end
        end
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int o, len, r;
    rst_n     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    in_len    = '0;
    for (int i = 0; i < N; i++) din[i] = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_result", result, 0);
    #10 rst_n = 1'b1;

    fill_random();
    for (int i = 0; i < 5; i++) vals[i] = i + 1;
    issue(0, 5, 1'b0);
    complete(0);

    fill_random();
    vals[0] = -128; vals[1] = 127; vals[2] = 0;
    issue(4, 3, 1'b0);
    complete(1);
    issue(5, 3, 1'b0);
    complete(2);

    fill_random();
    vals[0] = 5; vals[1] = 9; vals[2] = 9; vals[3] = 2;
    issue(7, 4, 1'b0);
    complete(0);

    issue(2, 0, 1'b0);
    complete(0);
    issue(0, 0, 1'b0);
    complete(1);

    fill_random();
    issue(3, 37, 1'b1);
    complete(3);

    fill_random();
    issue(0, 64, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrun_busy", busy, 0);
    chk("midrun_valid", out_valid, 0);
    chk("midrun_result", result, 0);
    sb.delete();
    seen = 1'b0;
    #10 rst_n = 1'b1;
    fill_random();
    issue(0, 64, 1'b0);
    complete(0);

    for (int t = 0; t < 40; t++) begin
      fill_random();
      o = $urandom_range(0, 7);
      r = $urandom_range(0, 9);
      if (r == 0)      len = 0;
      else if (r == 1) len = N;
      else if (r == 2) len = $urandom_range(N + 1, 127);
      else             len = $urandom_range(1, N - 1);
      issue(o, len, 1'($urandom_range(0, 1)));
      complete($urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
